pow2_32b_seq: RTL

//  Sequential base-2 antilog: converts fixed-point log value x = e + f (5-bit integer e,

---
 rtl/pow2_32b_seq_if.sv | 33 +++
 rtl/pow2_32b_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pow2_32b_seq_if.sv
// rtl/pow2_32b_seq_if.sv - handshake bundle for the pow2_32b_seq antilog block
//
// Groups the operand/result handshakes of pow2_32b_seq.
//   in_valid  : log_in valid (producer -> block)
//   in_ready  : block can accept an operand (high only while idle)
//   log_in    : {e[4:0], f[FRAC_W-1:0]} unsigned fixed-point log value
//   out_valid : pow_out valid (block -> consumer)
//   out_ready : consumer accepts pow_out
//   pow_out   : floor(2^(e+f)) approximation, 32 bits
//   busy      : block is iterating or shifting
// Modports: master drives operands and accepts results, slave is the block.

interface pow2_32b_seq_if #(
   parameter int FRAC_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [FRAC_W+4:0] log_in;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       pow_out;
   logic              busy;

   modport master (
      output in_valid, log_in, out_ready,
      input  in_ready, out_valid, pow_out, busy
   );

   modport slave (
      input  in_valid, log_in, out_ready,
      output in_ready, out_valid, pow_out, busy
   );
endinterface

// File: rtl/pow2_32b_seq.sv
// rtl/pow2_32b_seq.sv - sequential base-2 antilog, log_in = e + f -> floor(2^x)
//
// Converts the unsigned fixed-point log value x = e + f (5-bit integer e,
// FRAC_W-bit fraction f) into a 32-bit floor(2^x). The mantissa m is kept in
// Q2.30; each fraction bit of weight 2^-k multiplies m by C_k = 2^(2^-k)
// (one bit per cycle, MSB first), then a single barrel shift applies 2^e.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pow2_32b_seq_if.slave (in_valid/in_ready/log_in,
//           out_valid/out_ready/pow_out, busy)
//
// Build option POW2_MITCHELL_EN: replaces the iterative multiply path with the
// Mitchell linear approximation 2^f ~= 1 + f, loaded straight from IDLE; the
// ITER state and the constant ROM disappear. Handshake and reset are unchanged.

module pow2_32b_seq #(
   parameter int FRAC_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   pow2_32b_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] ONE_Q30 = 32'h4000_0000;

   state_t             state;
   state_t             state_nx;
   logic [4:0]         e_q;
   logic [31:0]        m;
   logic [31:0]        pow_q;
   logic [31:0]        pow_nx;
   logic [4:0]         op_e;
   logic [FRAC_W-1:0]  op_f;

   assign op_e = bus.log_in[FRAC_W+4:FRAC_W];
   assign op_f = bus.log_in[FRAC_W-1:0];

   // m < 2^31, so m << 31 stays inside 64 bits; the final >> 30 floors the result.
   assign pow_nx = 32'(({32'b0, m} << e_q) >> 30);

`ifndef POW2_MITCHELL_EN
   localparam logic [4:0] LAST = 5'(FRAC_W - 1);

   logic [4:0]        cnt;
   logic [FRAC_W-1:0] f_q;
   logic [31:0]       m_mul;

   // C_k = round(2^(2^-k) * 2^30)
   function automatic logic [31:0] rom_c(input logic [4:0] k);
      case (k)
         5'd1:    rom_c = 32'h5A82_799A;
         5'd2:    rom_c = 32'h4C1B_F829;
         5'd3:    rom_c = 32'h45CA_E0F2;
         5'd4:    rom_c = 32'h42D5_61B4;
         5'd5:    rom_c = 32'h4166_C34C;
         5'd6:    rom_c = 32'h40B2_68FA;
         5'd7:    rom_c = 32'h4058_F6A8;
         5'd8:    rom_c = 32'h402C_6BE9;
         5'd9:    rom_c = 32'h4016_321B;
         5'd10:   rom_c = 32'h400B_1818;
         5'd11:   rom_c = 32'h4005_8BCE;
         5'd12:   rom_c = 32'h4002_C5D8;
         5'd13:   rom_c = 32'h4001_62E8;
         5'd14:   rom_c = 32'h4000_B173;
         5'd15:   rom_c = 32'h4000_58B9;
         5'd16:   rom_c = 32'h4000_2C5D;
         default: rom_c = ONE_Q30;
      endcase
   endfunction

   // Q2.30 x Q2.30 product renormalised back to Q2.30 by truncation.
   assign m_mul = 32'(({32'b0, m} * {32'b0, rom_c(cnt + 5'd1)}) >> 30);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
`ifdef POW2_MITCHELL_EN
               state_nx = SHIFT;
`else
               state_nx = ITER;
`endif
            end
         end
         ITER: begin
`ifdef POW2_MITCHELL_EN
            state_nx = SHIFT;
`else
            if (cnt == LAST) begin
               state_nx = SHIFT;
            end
`endif
         end
         SHIFT: state_nx = DONE;
         DONE: begin
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE:        bus.in_ready  = 1'b1;
         ITER, SHIFT: bus.busy      = 1'b1;
         DONE:        bus.out_valid = 1'b1;
         default:     bus.in_ready  = 1'b0;
      endcase
   end

   assign bus.pow_out = pow_q;

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q   <= 5'd0;
         m     <= 32'd0;
         pow_q <= 32'd0;
`ifndef POW2_MITCHELL_EN
         cnt   <= 5'd0;
         f_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  e_q <= op_e;
`ifdef POW2_MITCHELL_EN
                  m   <= ONE_Q30 + (32'(op_f) << (30 - FRAC_W));
`else
                  m   <= ONE_Q30;
                  cnt <= 5'd0;
                  f_q <= op_f;
`endif
               end
            end
`ifndef POW2_MITCHELL_EN
            ITER: begin
               // f_q shifts left so its MSB is always the bit of weight 2^-(cnt+1).
               if (f_q[FRAC_W-1]) begin
                  m <= m_mul;
               end
               f_q <= f_q << 1;
               cnt <= cnt + 5'd1;
            end
`endif
            SHIFT: pow_q <= pow_nx;
            default: ;
         endcase
      end
   end

endmodule
